// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters; one full
// transaction (request, memory access, response) is in flight at a time.

typedef enum logic [2:0] {mt_b, mt_bu, mt_h, mt_hu, mt_w, mt_x} ME_MaskType;
typedef enum logic {me_rd, me_wr} ME_AccessType;

typedef struct packed {
    logic [31:0]  addrin;
    logic [31:0]  datain;
    ME_MaskType   mask;
    ME_AccessType req;
} CUtoME_IF;

typedef struct packed {
    logic [31:0] loadeddata;
} MEtoCU_IF;

module mem_port_arbiter (
    input  logic     clk,
    input  logic     rst,
    input  CUtoME_IF req0,
    input  CUtoME_IF req1,
    input  logic     req0_notify,
    input  logic     req1_notify,
    output logic     req0_sync,
    output logic     req1_sync,
    output MEtoCU_IF resp0,
    output MEtoCU_IF resp1,
    input  logic     resp0_notify,
    input  logic     resp1_notify,
    output logic     resp0_sync,
    output logic     resp1_sync,
    output CUtoME_IF mem_req,
    output logic     mem_req_notify,
    input  logic     mem_req_sync,
    input  MEtoCU_IF mem_resp,
    output logic     mem_resp_notify,
    input  logic     mem_resp_sync
);
    typedef enum logic [2:0] {IDLE, MREQ, MRESP, RESP, DONE} state_t;

    localparam CUtoME_IF REQ_RST = '{addrin: 32'h0, datain: 32'h0, mask: mt_w, req: me_rd};

    state_t   state, stateNxt;
    logic     last, lastNxt;
    CUtoME_IF memReqR, memReqNxt;
    logic     memReqNotifyR, memReqNotifyNxt;
    logic     memRespNotifyR, memRespNotifyNxt;
    logic [1:0] reqSyncR, reqSyncNxt;
    logic [1:0] respSyncR, respSyncNxt;
    MEtoCU_IF dataR, dataNxt;
    logic     grantSel;

    // last also names the requester owning the current transaction
    always_comb begin
        stateNxt         = state;
        lastNxt          = last;
        memReqNxt        = memReqR;
        memReqNotifyNxt  = memReqNotifyR;
        memRespNotifyNxt = memRespNotifyR;
        reqSyncNxt       = 2'b00;
        respSyncNxt      = 2'b00;
        dataNxt          = dataR;
        grantSel         = (req0_notify && req1_notify) ? !last : req1_notify;
        case (state)
            IDLE: begin
                if (req0_notify || req1_notify) begin
                    memReqNxt       = grantSel ? req1 : req0;
                    reqSyncNxt      = grantSel ? 2'b10 : 2'b01;
                    memReqNotifyNxt = 1'b1;
                    lastNxt         = grantSel;
                    stateNxt        = MREQ;
                end
            end
            MREQ: begin
                if (mem_req_sync) begin
                    memReqNotifyNxt  = 1'b0;
                    memRespNotifyNxt = 1'b1;
                    stateNxt         = MRESP;
                end
            end
            MRESP: begin
                if (mem_resp_sync) begin
                    dataNxt          = mem_resp;
                    memRespNotifyNxt = 1'b0;
                    stateNxt         = RESP;
                end
            end
            RESP: begin
                if (last ? resp1_notify : resp0_notify) begin
                    respSyncNxt = last ? 2'b10 : 2'b01;
                    stateNxt    = DONE;
                end
            end
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            last           <= 1'b1;
            memReqR        <= REQ_RST;
            memReqNotifyR  <= 1'b0;
            memRespNotifyR <= 1'b0;
            reqSyncR       <= 2'b00;
            respSyncR      <= 2'b00;
            dataR          <= '0;
        end else begin
            state          <= stateNxt;
            last           <= lastNxt;
            memReqR        <= memReqNxt;
            memReqNotifyR  <= memReqNotifyNxt;
            memRespNotifyR <= memRespNotifyNxt;
            reqSyncR       <= reqSyncNxt;
            respSyncR      <= respSyncNxt;
            dataR          <= dataNxt;
        end
    end

    assign req0_sync       = reqSyncR[0];
    assign req1_sync       = reqSyncR[1];
    assign resp0_sync      = respSyncR[0];
    assign resp1_sync      = respSyncR[1];
    assign resp0           = dataR;
    assign resp1           = dataR;
    assign mem_req         = memReqR;
    assign mem_req_notify  = memReqNotifyR;
    assign mem_resp_notify = memRespNotifyR;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized phase, checked cycle by cycle against a
// transaction-level model of the round-robin arbitration and handshakes.

module tb_mem_port_arbiter;
    logic     clk = 1'b0;
    logic     rst;
    CUtoME_IF req0, req1, mem_req;
    logic     req0_notify, req1_notify, req0_sync, req1_sync;
    MEtoCU_IF resp0, resp1, mem_resp;
    logic     resp0_notify, resp1_notify, resp0_sync, resp1_sync;
    logic     mem_req_notify, mem_req_sync, mem_resp_notify, mem_resp_sync;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .req0_notify(req0_notify), .req1_notify(req1_notify),
        .req0_sync(req0_sync), .req1_sync(req1_sync),
        .resp0(resp0), .resp1(resp1),
        .resp0_notify(resp0_notify), .resp1_notify(resp1_notify),
        .resp0_sync(resp0_sync), .resp1_sync(resp1_sync),
        .mem_req(mem_req), .mem_req_notify(mem_req_notify), .mem_req_sync(mem_req_sync),
        .mem_resp(mem_resp), .mem_resp_notify(mem_resp_notify), .mem_resp_sync(mem_resp_sync)
    );

    localparam CUtoME_IF REQ_RST = '{addrin: 32'h0, datain: 32'h0, mask: mt_w, req: me_rd};

    int checks = 0;
    int failures = 0;

    // model and environment state
    int          cycN = 0;
    bit          idle, doneFlag, respWait, lastM;
    int          phase;               // 0 none, 1 awaiting mem_req_sync, 2 awaiting mem_resp_sync
    CUtoME_IF    grantPay;
    logic [31:0] expData;
    int          reqCnt[2];
    int          respCnt[2];
    int          grantCyc, respCyc, mrnHigh;
    logic [31:0] addrLog[$];
    int          reqStall, respStall, reqStallCfg, respStallCfg;
    bit          randStall, autoReq, holdReq, respAuto, garbage, useForce;
    logic [31:0] forceData;

    task automatic chkB(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkI(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkD(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkP(input string tag, input CUtoME_IF obs, input CUtoME_IF exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic CUtoME_IF randPay();
        CUtoME_IF p;
        p.addrin = $urandom;
        p.datain = $urandom;
        p.mask   = ME_MaskType'(3'($urandom_range(0, 5)));
        p.req    = ME_AccessType'(1'($urandom_range(0, 1)));
        return p;
    endfunction

    task automatic clearStats();
        reqCnt[0] = 0; reqCnt[1] = 0;
        respCnt[0] = 0; respCnt[1] = 0;
        mrnHigh = 0;
        addrLog.delete();
    endtask

    task automatic doReset();
        #2 rst = 1'b1;
        #1;
        chkB("rst_req0_sync", req0_sync, 1'b0);
        chkB("rst_req1_sync", req1_sync, 1'b0);
        chkB("rst_resp0_sync", resp0_sync, 1'b0);
        chkB("rst_resp1_sync", resp1_sync, 1'b0);
        chkB("rst_mem_req_notify", mem_req_notify, 1'b0);
        chkB("rst_mem_resp_notify", mem_resp_notify, 1'b0);
        chkP("rst_mem_req", mem_req, REQ_RST);
        chkD("rst_resp_data", resp0.loadeddata, 32'h0);
        mem_req_sync = 1'b0;
        mem_resp_sync = 1'b0;
        idle = 1'b1; doneFlag = 1'b0; respWait = 1'b0; lastM = 1'b1;
        phase = 0; grantPay = REQ_RST;
        clearStats();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // One clock: model prediction, comparison of every handshake output, then environment reaction.
    task automatic cyc();
        bit p0, p1, rn0, rn1, idlePrev, rwPrev, mqx, mrx, expResp, g, w;
        CUtoME_IF pay0, pay1;
        p0 = req0_notify; p1 = req1_notify; pay0 = req0; pay1 = req1;
        rn0 = resp0_notify; rn1 = resp1_notify;
        idlePrev = idle; rwPrev = respWait;
        mqx = mem_req_notify && mem_req_sync;
        mrx = mem_resp_notify && mem_resp_sync;
        @(posedge clk);
        #1;
        cycN++;
        if (doneFlag) begin idle = 1'b1; doneFlag = 1'b0; end
        if (mqx) phase = 2;
        if (mrx) begin phase = 0; respWait = 1'b1; end
        expResp = rwPrev && (lastM ? rn1 : rn0);
        chkB("resp0_sync", resp0_sync, expResp && !lastM);
        chkB("resp1_sync", resp1_sync, expResp && lastM);
        if (expResp) begin
            chkD("resp_data", lastM ? resp1.loadeddata : resp0.loadeddata, expData);
            respWait = 1'b0; doneFlag = 1'b1;
            respCnt[lastM]++; respCyc = cycN;
        end
        g = idlePrev && (p0 || p1);
        w = (p0 && p1) ? !lastM : p1;
        if (g) begin
            lastM = w; idle = 1'b0; phase = 1;
            grantPay = w ? pay1 : pay0;
            reqCnt[w]++; grantCyc = cycN;
            addrLog.push_back(grantPay.addrin);
            reqStall  = randStall ? $urandom_range(0, 3) : reqStallCfg;
            respStall = randStall ? $urandom_range(0, 3) : respStallCfg;
        end
        chkB("req0_sync", req0_sync, g && !w);
        chkB("req1_sync", req1_sync, g && w);
        chkB("mem_req_notify", mem_req_notify, phase == 1);
        chkB("mem_resp_notify", mem_resp_notify, phase == 2);
        chkP("mem_req", mem_req, grantPay);
        if (mem_req_notify) mrnHigh++;

        if (g && !holdReq) begin
            if (w) req1_notify = 1'b0; else req0_notify = 1'b0;
        end
        if (autoReq) begin
            if (!req0_notify && $urandom_range(0, 2) == 0) begin req0 = randPay(); req0_notify = 1'b1; end
            if (!req1_notify && $urandom_range(0, 2) == 0) begin req1 = randPay(); req1_notify = 1'b1; end
        end
        if (respAuto) begin
            resp0_notify = 1'($urandom_range(0, 1));
            resp1_notify = 1'($urandom_range(0, 1));
        end
        if (mem_req_notify) begin
            if (reqStall == 0) mem_req_sync = 1'b1;
            else begin mem_req_sync = 1'b0; reqStall--; end
        end else begin
            mem_req_sync = garbage && ($urandom_range(0, 3) == 0);
        end
        if (mem_resp_notify) begin
            if (respStall == 0) begin
                mem_resp_sync = 1'b1;
                mem_resp.loadeddata = useForce ? forceData : $urandom;
                expData = mem_resp.loadeddata;
            end else begin
                mem_resp_sync = 1'b0; respStall--;
            end
        end else begin
            mem_resp_sync = garbage && ($urandom_range(0, 3) == 0);
            if (garbage) mem_resp.loadeddata = $urandom;
        end
    endtask

    task automatic waitResp(input int n, input int bound, input string tag);
        int k;
        k = 0;
        while ((respCnt[0] + respCnt[1]) < n && k < bound) begin cyc(); k++; end
        chkB({tag, "_completed"}, (respCnt[0] + respCnt[1]) >= n, 1'b1);
    endtask

    initial begin
        int c0;
        rst = 1'b0;
        req0 = REQ_RST; req1 = REQ_RST;
        req0_notify = 1'b0; req1_notify = 1'b0;
        resp0_notify = 1'b1; resp1_notify = 1'b1;
        mem_req_sync = 1'b0; mem_resp_sync = 1'b0; mem_resp = '0;
        reqStallCfg = 0; respStallCfg = 0;
        randStall = 1'b0; autoReq = 1'b0; holdReq = 1'b0; respAuto = 1'b0; garbage = 1'b0;
        useForce = 1'b0; forceData = 32'h0;
        doReset();

        // single load, best-case latency
        useForce = 1'b1; forceData = 32'hDEADBEEF;
        req0 = '{addrin: 32'h100, datain: 32'h0, mask: mt_w, req: me_rd};
        req0_notify = 1'b1;
        c0 = cycN;
        waitResp(1, 20, "load");
        chkI("load_grant_cycle", grantCyc, c0 + 1);
        chkI("load_resp_cycle", respCyc, c0 + 4);
        chkD("load_addr", addrLog[0], 32'h100);
        chkI("load_req1_grants", reqCnt[1], 0);
        chkI("load_resp1_count", respCnt[1], 0);
        cyc();
        useForce = 1'b0;

        // persistent simultaneous requests alternate 0,1,0,1
        doReset();
        req0 = '{addrin: 32'h10, datain: 32'h0, mask: mt_w, req: me_rd};
        req1 = '{addrin: 32'h20, datain: 32'h0, mask: mt_w, req: me_rd};
        req0_notify = 1'b1; req1_notify = 1'b1; holdReq = 1'b1;
        waitResp(4, 40, "alt");
        req0_notify = 1'b0; req1_notify = 1'b0; holdReq = 1'b0;
        cyc(); cyc();
        chkI("alt_grant_total", addrLog.size(), 4);
        chkD("alt_addr0", addrLog[0], 32'h10);
        chkD("alt_addr1", addrLog[1], 32'h20);
        chkD("alt_addr2", addrLog[2], 32'h10);
        chkD("alt_addr3", addrLog[3], 32'h20);
        chkI("alt_req0_syncs", reqCnt[0], 2);
        chkI("alt_req1_syncs", reqCnt[1], 2);
        chkI("alt_resp0_syncs", respCnt[0], 2);
        chkI("alt_resp1_syncs", respCnt[1], 2);

        // store with memory stalls
        clearStats();
        reqStallCfg = 3; respStallCfg = 2;
        req1 = '{addrin: 32'h44, datain: 32'h12345678, mask: mt_b, req: me_wr};
        req1_notify = 1'b1;
        waitResp(1, 30, "store");
        chkI("store_mem_req_notify_cycles", mrnHigh, 4);
        chkP("store_payload", mem_req, '{addrin: 32'h44, datain: 32'h12345678, mask: mt_b, req: me_wr});
        chkI("store_resp1_pulses", respCnt[1], 1);
        cyc();
        reqStallCfg = 0; respStallCfg = 0;

        // requester not ready for its response
        clearStats();
        resp0_notify = 1'b0;
        req0 = '{addrin: 32'h200, datain: 32'h0, mask: mt_w, req: me_rd};
        req0_notify = 1'b1;
        cyc();
        req1 = '{addrin: 32'h300, datain: 32'h0, mask: mt_h, req: me_rd};
        req1_notify = 1'b1;
        for (int k = 0; k < 10 && !respWait; k++) cyc();
        chkB("nr_reached_resp", respWait, 1'b1);
        repeat (5) cyc();
        chkI("nr_resp0_held", respCnt[0], 0);
        resp0_notify = 1'b1;
        cyc();
        chkB("nr_resp0_sync", resp0_sync, 1'b1);
        chkI("nr_req1_not_granted", reqCnt[1], 0);
        waitResp(2, 20, "nr_req1");
        chkI("nr_req1_granted", reqCnt[1], 1);
        cyc();

        // reset while the memory response is outstanding
        clearStats();
        respStallCfg = 20;
        req0 = '{addrin: 32'h400, datain: 32'h0, mask: mt_w, req: me_rd};
        req0_notify = 1'b1;
        for (int k = 0; k < 10 && phase != 2; k++) cyc();
        chkI("mr_in_mresp", phase, 2);
        cyc();
        req0 = '{addrin: 32'h600, datain: 32'h0, mask: mt_w, req: me_rd};
        req1 = '{addrin: 32'h500, datain: 32'h0, mask: mt_w, req: me_rd};
        req0_notify = 1'b1; req1_notify = 1'b1;
        doReset();
        respStallCfg = 0;
        waitResp(1, 20, "mr_first");
        chkD("mr_first_addr", addrLog[0], 32'h600);
        chkI("mr_req1_waits", reqCnt[1], 0);
        waitResp(2, 20, "mr_second");
        chkD("mr_second_addr", addrLog[1], 32'h500);
        cyc();

        // randomized traffic with stalls, random readiness and stray syncs
        clearStats();
        autoReq = 1'b1; respAuto = 1'b1; randStall = 1'b1; garbage = 1'b1;
        repeat (600) cyc();
        chkB("rand_progress", (respCnt[0] + respCnt[1]) > 30, 1'b1);
        chkB("rand_both_served", (respCnt[0] > 0) && (respCnt[1] > 0), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one memory port (CUtoME_IF request / MEtoCU_IF response, notify/sync handshakes) between two ISS-style masters, e.g. two cores or a split fetch/data path. It grants one complete transaction at a time: request, memory access and response. It uses round-robin priority and sits between the masters' memory ports and the single memory model.

## Interface
- Parameters: none; fixed at two requesters.
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  CUtoME_IF  request payload: addrin, datain, mask, req
- req0_notify, req1_notify  in  1  requester has a valid request
- req0_sync, req1_sync  out  1  one-cycle pulse: request accepted
- resp0, resp1  out  MEtoCU_IF  response payload (loadeddata)
- resp0_notify, resp1_notify  in  1  requester ready to take a response
- resp0_sync, resp1_sync  out  1  one-cycle pulse: response delivered
- mem_req  out  CUtoME_IF  request forwarded to memory
- mem_req_notify  out  1  forwarded request valid
- mem_req_sync  in  1  memory accepted the request
- mem_resp  in  MEtoCU_IF  memory response
- mem_resp_notify  out  1  arbiter ready for the memory response
- mem_resp_sync  in  1  memory response valid

## Operation
- Handshake rule: a transfer occurs in the cycle where notify and sync are both 1. Senders hold notify and payload until then.
- All outputs are registered. resp0 and resp1 both carry the same internal data register. Each is meaningful only in the cycle its sync pulses.
- Round-robin pointer `last` records the most recently granted requester. On reset `last` = 1, so requester 0 wins the first tie.
- States and transitions:
  - IDLE
    - If neither notify is set: stay.
    - If exactly one notify is set: grant it (g).
    - If both are set: g = !last.
    - On a grant: latch req_g into mem_req; set req_g_sync<=1, mem_req_notify<=1, last<=g; go to MREQ.
  - MREQ
    - req_g_sync<=0, so the sync pulse is exactly one cycle.
    - On mem_req_sync: mem_req_notify<=0, mem_resp_notify<=1; go to MRESP.
  - MRESP
    - On mem_resp_sync: latch mem_resp.loadeddata, mem_resp_notify<=0; go to RESP.
  - RESP
    - On resp_g_notify: resp_g_sync<=1; go to DONE.
  - DONE
    - resp_g_sync<=0; go to IDLE.
- Both loads (me_rd) and stores (me_wr) follow the full sequence. A store's response data is forwarded unmodified.
- Ignored inputs:
  - The non-granted requester's notify lines while busy. It stays pending and wins the next arbitration if the other requester re-requests.
  - mem_resp_sync outside MRESP.
  - mem_req_sync outside MREQ.
  - resp_notify of the non-granted requester.
- If a requester drops notify after its grant (protocol violation), the transaction still completes.

## Timing
- Reset values:
  - state=IDLE, last=1.
  - All *_sync and *_notify outputs 0.
  - mem_req = {addrin 0, datain 0, mask mt_w, req me_rd}.
  - resp data 0.
- Reset is honoured in any state. A mid-transaction reset abandons the outstanding access and issues no response.
- Best-case latency (memory and requester always ready), with the request sampled in IDLE at cycle 0:
  - cycle 1: req_g_sync=1, mem_req_notify=1.
  - cycle 2: mem_resp_notify=1.
  - cycle 3: state RESP.
  - cycle 4: resp_g_sync=1.
  - cycle 5: IDLE, next grant sampled.
- Minimum spacing between grants is 5 cycles. Each memory-side stall adds cycles 1:1.
- mem_req is stable from cycle 1 until the next grant.
- Persistent simultaneous requests alternate strictly: 0, 1, 0, 1, …

## Test plan
- Single load: req0 = {addrin 0x100, mask mt_w, req me_rd}, memory returns 0xDEADBEEF with immediate syncs.
  - mem_req.addrin=0x100 at cycle 1.
  - resp0_sync pulses at cycle 4 with resp0.loadeddata=0xDEADBEEF.
  - req1_sync and resp1_sync stay 0.
- Simultaneous requests after reset, req0 addr 0x10 and req1 addr 0x20, both held high:
  - Order of mem_req.addrin is 0x10, 0x20, 0x10, 0x20.
  - Each requester gets exactly one req_sync and one resp_sync per transaction.
- Store with stalls: req1 = {addrin 0x44, datain 0x12345678, mask mt_b, req me_wr}, mem_req_sync delayed 3 cycles, mem_resp_sync delayed 2 cycles.
  - mem_req_notify is held 4 cycles.
  - mem_req payload matches req1 exactly.
  - resp1_sync is a single pulse.
- Requester not ready: resp0_notify low for 5 cycles after MRESP completes.
  - Arbiter waits in RESP with no sync.
  - resp0_sync pulses the cycle after resp0_notify rises.
  - req1 is not granted meanwhile.
- Reset mid-transaction: assert rst while in MRESP.
  - All notify/sync outputs go to 0 immediately.
  - mem_req returns to {0, 0, mt_w, me_rd}.
  - After release, a pending req0 and req1 resolve to requester 0 first.
